// File: rtl/riscv.sv
// Single-cycle RV32I-subset core with built-in ROM, data RAM and register file.
// PROG overrides the first 16 ROM words; the default is the boot program.
module riscv #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter logic [16*32-1:0] PROG = {
    {12{32'h0000_0013}},
    32'h0000_006F,
    32'h0062_83B3,
    32'h0040_0313,
    32'h0010_0293
  }
) (
  input logic clk,
  input logic rst
);

  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc;
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];

  logic [5:0]  iidx;
  logic [31:0] instr;

  assign iidx = 6'(pc >> 2);

  always_comb begin
    instr = NOP;
    if (int'(iidx) < IMEM_WORDS && iidx < 6'd16)
      instr = PROG[{iidx[3:0], 5'b0} +: 32];
  end

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] a, b;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  assign a = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign b = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  function automatic logic [31:0] alu(
    input logic [2:0]  op,
    input logic        sub,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [31:0] r;
    r = 32'd0;
    unique case (op)
      3'd0: r = sub ? x - y : x + y;
      3'd2: r = {31'd0, $signed(x) < $signed(y)};
      3'd3: r = {31'd0, x < y};
      3'd4: r = x ^ y;
      3'd6: r = x | y;
      3'd7: r = x & y;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui;

  assign is_r    = opcode == 7'h33;
  assign is_i    = opcode == 7'h13;
  assign is_ld   = opcode == 7'h03;
  assign is_st   = opcode == 7'h23;
  assign is_br   = opcode == 7'h63;
  assign is_jal  = opcode == 7'h6F;
  assign is_jalr = opcode == 7'h67;
  assign is_lui  = opcode == 7'h37;

  logic [31:0] pc4, next_pc, wb_data, addr;
  logic        wb_en, mem_we, take;
  logic [DAW-1:0] didx;

  assign pc4  = pc + 32'd4;
  assign addr = a + (is_st ? imm_s : imm_i);
  assign didx = DAW'(addr >> 2);

  always_comb begin
    next_pc = pc4;
    wb_en   = 1'b0;
    wb_data = 32'd0;
    mem_we  = 1'b0;
    take    = 1'b0;
    unique case (1'b1)
      is_r: begin
        wb_en = (f7 == 7'h00 && f3 != 3'd1 && f3 != 3'd5)
             || (f7 == 7'h20 && f3 == 3'd0);
        wb_data = alu(f3, f7[5], a, b);
      end
      is_i: begin
        wb_en = f3 != 3'd1 && f3 != 3'd3 && f3 != 3'd5;
        wb_data = alu(f3, 1'b0, a, imm_i);
      end
      is_ld: begin
        wb_en   = f3 == 3'd2;
        wb_data = dmem[didx];
      end
      is_st: mem_we = f3 == 3'd2;
      is_br: begin
        unique case (f3)
          3'd0: take = a == b;
          3'd1: take = a != b;
          3'd4: take = $signed(a) < $signed(b);
          3'd5: take = $signed(a) >= $signed(b);
          default: take = 1'b0;
        endcase
        if (take) next_pc = pc + imm_b;
      end
      is_jal: begin
        wb_en   = 1'b1;
        wb_data = pc4;
        next_pc = pc + imm_j;
      end
      is_jalr: begin
        if (f3 == 3'd0) begin
          wb_en   = 1'b1;
          wb_data = pc4;
          next_pc = (a + imm_i) & ~32'd1;
        end
      end
      is_lui: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
    end
  end

  // RAM is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (rst && mem_we) dmem[didx] <= b;
  end

endmodule

// File: tb/tb_riscv.sv
// Directed bench: boot program, reset behaviour and three ROM variants.
// Architectural state is observed hierarchically (regs, pc, dmem).
module tb_riscv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  riscv u_boot (.clk(clk), .rst(rst));

  riscv #(.PROG({
    {13{32'h0000_0013}},
    32'h0000_006F,
    32'h0000_0433,
    32'h0070_0013
  })) u_x0 (.clk(clk), .rst(rst));

  riscv #(.PROG({
    {9{32'h0000_0013}},
    32'h0000_006F,
    32'h0090_0213,
    32'h0010_0193,
    32'h0020_8463,
    32'h0080_2103,
    32'h0010_2423,
    32'hFFD0_0093
  })) u_mem (.clk(clk), .rst(rst));

  riscv #(.PROG({
    {7{32'h0000_0013}},
    32'h0000_006F,
    32'h0050_0793,
    32'h0200_0767,
    32'h00B5_36B3,
    32'h00B5_2633,
    32'h0010_0593,
    32'hFFF0_0513,
    32'h0030_0493,
    32'h0080_00EF
  })) u_jal (.clk(clk), .rst(rst));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    step(2);
    chk("rst pc", u_boot.pc, 32'h0);
    for (int i = 1; i < 32; i++)
      chk($sformatf("rst x%0d", i), u_boot.regs[i], 32'h0);

    rst = 1'b1;
    step(1);
    chk("boot x5 e1", u_boot.regs[5], 32'd1);
    step(1);
    chk("boot x6 e2", u_boot.regs[6], 32'd4);
    step(1);
    chk("boot x7 e3", u_boot.regs[7], 32'd5);
    step(10);
    chk("boot pc halt", u_boot.pc, 32'h0C);
    chk("boot x7 hold", u_boot.regs[7], 32'd5);
    chk("boot x0", u_boot.regs[0], 32'd0);

    chk("x0 var x0", u_x0.regs[0], 32'd0);
    chk("x0 var x8", u_x0.regs[8], 32'd0);
    chk("x0 var pc", u_x0.pc, 32'h08);

    chk("mem x1", u_mem.regs[1], 32'hFFFF_FFFD);
    chk("mem ram", u_mem.dmem[2], 32'hFFFF_FFFD);
    chk("mem x2", u_mem.regs[2], 32'hFFFF_FFFD);
    chk("mem skip x3", u_mem.regs[3], 32'd0);
    chk("mem x4", u_mem.regs[4], 32'd9);
    chk("mem pc", u_mem.pc, 32'h18);

    chk("jal x1", u_jal.regs[1], 32'd4);
    chk("jal skip x9", u_jal.regs[9], 32'd0);
    chk("slt", u_jal.regs[12], 32'd1);
    chk("sltu", u_jal.regs[13], 32'd0);
    chk("jalr link", u_jal.regs[14], 32'h1C);
    chk("jalr skip", u_jal.regs[15], 32'd0);
    chk("jalr pc", u_jal.pc, 32'h20);

    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    chk("mem br pc0", u_mem.pc, 32'h04);
    chk("jal pc e1", u_jal.pc, 32'h08);
    chk("jal x1 e1", u_jal.regs[1], 32'd4);
    step(2);
    chk("mem br pc3", u_mem.pc, 32'h0C);
    step(1);
    chk("mem br taken", u_mem.pc, 32'h14);

    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    chk("mid x5", u_boot.regs[5], 32'd1);
    chk("mid x6", u_boot.regs[6], 32'd4);
    rst = 1'b0;
    step(1);
    chk("mid rst pc", u_boot.pc, 32'h0);
    chk("mid rst x5", u_boot.regs[5], 32'd0);
    chk("mid rst x6", u_boot.regs[6], 32'd0);
    chk("mid rst x7", u_boot.regs[7], 32'd0);
    rst = 1'b1;
    step(3);
    chk("restart x7", u_boot.regs[7], 32'd5);
    chk("restart pc", u_boot.pc, 32'h0C);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv.md
Name: riscv

Overview:
- Single-cycle RV32I-subset processor core with internal instruction ROM, data RAM and 32x32 register file.
- Top-level block: only clock and reset cross the boundary.
- Verification observes the architectural state hierarchically.
- ROM holds a fixed boot program computing x7 = x5 + x6 = 1 + 4 = 5, then halting in a self-loop.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words (word-addressed by PC[7:2]).
- DMEM_WORDS, 64, data RAM depth in 32-bit words (word-addressed by addr[7:2]).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- rst  input  1  reset. One clock; reset is synchronous and active-low.

Behaviour:
- Reset: on posedge clk with rst==0:
  - PC <= 0.
  - All 32 registers <= 0.
  - Data RAM contents are not cleared.
  - No other state changes.
- Execution: when rst==1, one instruction completes per clock. Fetch, decode, execute, memory and writeback all occur combinationally within the cycle. PC and the register/RAM write are updated on the same posedge.
- PC update:
  - Default PC+4.
  - Taken branch / JAL: PC + sign-extended immediate.
  - JALR: (rs1 + imm) & ~1.
  - PC is 32 bits and wraps modulo 2^32.
  - ROM index uses PC[7:2]; upper bits are ignored, so fetch wraps every 256 bytes.
- Supported instructions:
  - R-type: add, sub, and, or, xor, slt, sltu.
  - I-type ALU: addi, andi, ori, xori, slti.
  - Loads/stores: lw, sw.
  - Branches: beq, bne, blt, bge.
  - Jumps: jal, jalr.
  - lui.
- Undefined opcodes execute as NOP: no register or memory write, PC+4.
- Immediates: I, S, B, J and U formats sign-extended per RV32I. B and J offsets are in bytes with bit0 = 0.
- Arithmetic: 32-bit two's complement with wrap-around and no overflow trap. slt is signed; sltu is unsigned.
- Register file:
  - 2 asynchronous read ports, 1 synchronous write port.
  - x0 reads 0 always; writes to x0 are discarded.
  - Read-during-write in the same cycle returns the old value; new values are visible next cycle.
- Data RAM:
  - Asynchronous read; synchronous word write on posedge when sw and rst==1.
  - Address bits [1:0] are ignored, no misalignment trap.
- jal/jalr write PC+4 to rd.
- Boot ROM contents (byte address: word):
  - 0x00: 0x00100293 — addi x5,x0,1
  - 0x04: 0x00400313 — addi x6,x0,4
  - 0x08: 0x006283B3 — add x7,x5,x6
  - 0x0C: 0x0000006F — jal x0,0, the halt loop
  - All other words are 0x00000013 (NOP).
- Timing from the first posedge with rst==1, after reset: x5=1 after edge 1, x6=4 after edge 2, x7=5 after edge 3. From edge 4 onward PC stays at 0x0C permanently.
- Reset mid-operation: a posedge with rst==0 overrides any pending write. No register/RAM write occurs on that edge; PC and registers return to 0 and the boot program restarts.
- Hierarchical visibility for the bench: register array and PC must be readable as named internal signals (register file storage, 32 entries x 32 bits; program counter, 32 bits).

Test Plan:
- Reset: hold rst=0 for 2 edges -> PC=0, x1..x31=0.
- Boot program: release rst=1, run 3 edges -> x5=1, x6=4, x7=5; run 10 more edges -> PC=0x0C, x7 still 5, x0=0.
- Mid-run reset: release, 2 edges (x5=1, x6=4), then rst=0 for 1 edge -> PC=0, x5=x6=x7=0. Release again -> x7=5 after 3 more edges.
- x0 hardwiring: ROM variant with addi x0,x0,7 then add x8,x0,x0 -> x0=0, x8=0.
- Memory/branch: ROM variant with addi x1,x0,-3; sw x1,8(x0); lw x2,8(x0); beq x1,x2,+8 -> x2=0xFFFFFFFD and branch taken: PC goes 0x0C -> 0x14, and the instruction at 0x10 is skipped.
- Jump link / slt: ROM variant with jal x1,+8 at 0x00 -> x1=4, PC=0x08. slt with x=-1,y=1 yields 1; sltu with the same operands yields 0.
